// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the hardwired-zero register
// address and the register-address type used by decode and writeback.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 4'h0;

endpackage

// File: rtl/register_16bit.sv
// Single data register with asynchronous active-low clear and write enable.
// Used for R1..R15 of the register file; R0 is a constant in the top.
module register_16bit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear immediately on reset, otherwise load on an enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_16x16.sv
// 16 x 16-bit register file with two combinational read ports and one
// write port. R0 always reads zero and ignores writes.
// Optional build macro REGFILE_BYPASS_EN: forwards DstData to a read port
// that selects the register being written in the same cycle, so a
// writeback result can feed the add/sub unit without a stall.
module reg_file_16x16
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2
);

  import cpu_pkg::REG_ZERO;

  logic [NUM_REGS-1:1] wr_sel;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   rd_data1;
  logic [DATA_W-1:0]   rd_data2;

  // One-hot write select; there is no select line for R0, so writes to
  // address zero fall away naturally.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_sel[i] = WriteReg && (DstReg == ADDR_W'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    register_16bit #(
      .WIDTH (DATA_W)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_sel[i]),
      .d     (DstData),
      .q     (regs[i])
    );
  end

  // Read muxes: every select value is decoded, address zero returns zero.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (SrcReg1 != ADDR_W'(REG_ZERO)) rd_data1 = regs[SrcReg1];
    if (SrcReg2 != ADDR_W'(REG_ZERO)) rd_data2 = regs[SrcReg2];
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = rst_n && WriteReg && (DstReg != ADDR_W'(REG_ZERO));

  // Same-cycle forwarding of write data onto a matching read port.
  always_comb begin
    SrcData1 = rd_data1;
    SrcData2 = rd_data2;
    if (fwd_ok && (SrcReg1 == DstReg)) SrcData1 = DstData;
    if (fwd_ok && (SrcReg2 == DstReg)) SrcData2 = DstData;
  end
`else
  // No forwarding: a register being written reads its old value until the edge.
  always_comb begin
    SrcData1 = rd_data1;
    SrcData2 = rd_data2;
  end
`endif

endmodule

// File: tb/tb_reg_file_16x16.sv
module tb_reg_file_16x16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  SrcReg1, SrcReg2, DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1, SrcData2;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [16];

  reg_file_16x16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SrcReg1  (SrcReg1),
    .SrcReg2  (SrcReg2),
    .DstReg   (DstReg),
    .WriteReg (WriteReg),
    .DstData  (DstData),
    .SrcData1 (SrcData1),
    .SrcData2 (SrcData2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: an array of values, cleared by reset, loaded on edges.
  always @(negedge rst_n) begin
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
  end

  always @(posedge clk) begin
    if (rst_n && WriteReg && DstReg != 4'd0) mdl[DstReg] = DstData;
  end

  function automatic logic [15:0] exp_rd(input logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    if (rst_n && WriteReg && DstReg != 4'd0 && a == DstReg) return DstData;
`endif
    if (a == 4'd0 || !rst_n) return 16'h0000;
    return mdl[a];
  endfunction

  // Continuous comparison of both read ports against the model.
  always @(negedge clk) begin
    logic [15:0] e1, e2;
    e1 = exp_rd(SrcReg1);
    e2 = exp_rd(SrcReg2);
    checks++;
    if (SrcData1 !== e1) begin
      errors++;
      $display("FAIL model_rd1 t=%0t sel=%0d got=%h exp=%h", $time, SrcReg1, SrcData1, e1);
    end
    checks++;
    if (SrcData2 !== e2) begin
      errors++;
      $display("FAIL model_rd2 t=%0t sel=%0d got=%h exp=%h", $time, SrcReg2, SrcData2, e2);
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] dst,
                       input logic we, input logic [15:0] data);
    SrcReg1 = s1; SrcReg2 = s2; DstReg = dst; WriteReg = we; DstData = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] e;
    rst_n = 0;
    drive(4'd5, 4'd0, 4'd0, 1'b0, 16'h0000);
    #12;
    chk("reset_rd1", SrcData1, 16'h0000);
    chk("reset_rd2", SrcData2, 16'h0000);
    next_cycle();
    rst_n = 1;

    // Async reset mid-cycle after writing R5.
    drive(4'd5, 4'd0, 4'd5, 1'b1, 16'hBEEF);
    next_cycle();
    drive(4'd5, 4'd0, 4'd5, 1'b0, 16'h0000);
    #1 chk("r5_written", SrcData1, 16'hBEEF);
    #1 rst_n = 0;
    #1 chk("async_clear", SrcData1, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1;
    next_cycle();
    chk("after_reset_release", SrcData1, 16'h0000);

    // Basic write/read.
    drive(4'd0, 4'd0, 4'd3, 1'b1, 16'h7FFF);
    next_cycle();
    drive(4'd0, 4'd0, 4'd4, 1'b1, 16'h8001);
    next_cycle();
    drive(4'd3, 4'd4, 4'd0, 1'b0, 16'h0000);
    #1 chk("r3_read", SrcData1, 16'h7FFF);
    chk("r4_read", SrcData2, 16'h8001);

    // R0 immunity.
    drive(4'd0, 4'd0, 4'd0, 1'b1, 16'h1234);
    next_cycle();
    WriteReg = 0;
    #1 chk("r0_zero", SrcData1, 16'h0000);

    // Dual-port same address and write-enable low.
    drive(4'd9, 4'd9, 4'd9, 1'b1, 16'hA5A5);
    next_cycle();
    drive(4'd9, 4'd9, 4'd9, 1'b0, 16'hFFFF);
    #1 chk("dual_rd1", SrcData1, 16'hA5A5);
    chk("dual_rd2", SrcData2, 16'hA5A5);
    next_cycle();
    chk("we_low_hold", SrcData1, 16'hA5A5);

    // Read-during-write.
    drive(4'd0, 4'd0, 4'd7, 1'b1, 16'h0001);
    next_cycle();
    drive(4'd7, 4'd0, 4'd7, 1'b1, 16'h0002);
`ifdef REGFILE_BYPASS_EN
    #1 chk("rdw_before_edge", SrcData1, 16'h0002);
`else
    #1 chk("rdw_before_edge", SrcData1, 16'h0001);
`endif
    next_cycle();
    WriteReg = 0;
    #1 chk("rdw_after_edge", SrcData1, 16'h0002);

    // Sweep: R[i] = 0x1111 * i, then read every pair.
    for (int i = 1; i < 16; i++) begin
      drive(4'd0, 4'd0, 4'(i), 1'b1, 16'(16'h1111 * i));
      next_cycle();
    end
    WriteReg = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        SrcReg1 = 4'(a);
        SrcReg2 = 4'(b);
        #1;
        e = 16'(16'h1111 * a);
        chk("sweep_rd1", SrcData1, e);
        e = 16'(16'h1111 * b);
        chk("sweep_rd2", SrcData2, e);
      end
    end
    next_cycle();

    // Randomized traffic, checked every cycle by the model compare.
    for (int n = 0; n < 3000; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 16'($urandom));
      if (($urandom_range(0, 15) == 0) && ($urandom_range(0, 1) == 0)) begin
        SrcReg1 = DstReg;
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 0;
        #1 chk("rand_async_clear", SrcData1, 16'h0000);
        #1 rst_n = 1;
      end
      next_cycle();
    end

    WriteReg = 0;
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry x 16-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the 16-bit saturating add/sub unit and drives its A and B operands from the SrcData1 and SrcData2 ports.
- Accepts one write per clock from the writeback path.
- R0 is hardwired to zero.

Parameters:
- DATA_W, 16, width of each register and each data port.
- ADDR_W, 4, width of each register-select port.
- NUM_REGS, 16, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all register state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register.
- SrcReg1  input  ADDR_W  select for read port 1, which feeds operand A.
- SrcReg2  input  ADDR_W  select for read port 2, which feeds operand B.
- DstReg  input  ADDR_W  select for the write port.
- WriteReg  input  1  write enable.
- DstData  input  DATA_W  write data, two's complement.
- SrcData1  output  DATA_W  read data for port 1.
- SrcData2  output  DATA_W  read data for port 2.

Behaviour:
- Reset:
  - rst_n low clears all NUM_REGS registers to 16'h0000 immediately, without waiting for clk.
  - While rst_n is low, writes are ignored and SrcData1/SrcData2 read 16'h0000.
  - Deasserting rst_n mid-cycle leaves contents at zero until the next qualifying rising edge.
- Write:
  - On the rising clk edge with WriteReg=1 and DstReg!=0, the selected register loads DstData.
  - WriteReg=0 leaves all registers unchanged.
  - A write with DstReg=0 is discarded.
- Read:
  - Fully combinational, zero-cycle latency from SrcRegN to SrcDataN.
  - Selecting address 0 always returns 16'h0000.
  - Both ports may select the same register simultaneously; each returns the identical value.
- Read-during-write:
  - Without the optional feature, a read of the register being written returns the pre-edge (old) value until the edge.
  - After the edge, it returns the new value.
- Width:
  - Data is stored and returned unmodified; there is no sign extension or saturation here.
  - Signedness is interpreted only by the downstream add/sub.
- No X propagation: every register has a defined reset value, and every read-mux select value is decoded.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: internal write-to-read forwarding is enabled.
  - If WriteReg=1, DstReg!=0 and SrcRegN==DstReg, then SrcDataN = DstData combinationally in the same cycle.
  - This lets a writeback result be read as an add/sub operand without a stall.
  - Forwarding is suppressed for R0 and while rst_n is low.
- Not defined: there is no forwarding; behaviour is exactly as stated under Read-during-write.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W and ADDR_W constants.
  - REG_ZERO = 4'h0.
  - A reg_addr_t typedef shared with the decoder and writeback stages.
- Natural sub-module: register_16bit, one 16-bit register with async active-low clear and write enable.
  - Instantiated 15 times for R1-R15.
  - R0 is a constant, not an instance.
- Write-select decoding (4-to-16 one-hot) and the two read muxes stay in the top module.

Test Plan:
- Reset: write 16'hBEEF to R5, then pulse rst_n low mid-cycle -> SrcData1 with SrcReg1=5 reads 16'h0000 immediately, without any clk edge.
- Basic write/read: write R3=16'h7FFF and R4=16'h8001 on consecutive edges; set SrcReg1=3, SrcReg2=4 -> SrcData1=16'h7FFF, SrcData2=16'h8001.
- R0 immunity: WriteReg=1, DstReg=0, DstData=16'h1234, then clock -> SrcData1 for SrcReg1=0 reads 16'h0000.
- Dual-port same address: R9=16'hA5A5 with SrcReg1=SrcReg2=9 -> both outputs 16'hA5A5; WriteReg=0 with DstReg=9, DstData=16'hFFFF, then clock -> R9 is still 16'hA5A5.
- Read-during-write: R7=16'h0001; in the same cycle drive DstReg=7, DstData=16'h0002, WriteReg=1, SrcReg1=7.
  - Before the edge, SrcData1=16'h0001 without REGFILE_BYPASS_EN, or 16'h0002 with it.
  - After the edge, 16'h0002 in both builds.
- Exhaustive sweep: write R1..R15 with value 16'h1111*index, then read all pairs -> every read matches, and R0 reads zero throughout.
